// File: rtl/clken_pkg.sv
// clken_pkg: shared constants and elaboration-time helpers for the bus-cycle
// enable sequencer.
//   clog2()      - width of the period counter for a given divider
//   params_ok()  - legality check for a sequencer parameter set
//   DEF_*        - default divider / sub-enable layout shared with the top
package clken_pkg;

  localparam int DEF_DIV         = 50;
  localparam int DEF_NSUB        = 4;
  localparam int DEF_SUB_SPACING = 8;

  // Bits needed to hold values 0 .. v-1 (at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Every sub-enable and the phi2 fall point must land inside one period,
  // and the wait-state clamp must fit the stretch input.
  function automatic bit params_ok(input int div, input int nsub,
                                   input int spacing, input int phi2_low_at,
                                   input int max_stretch, input int sw);
    return (div >= 4) && (nsub * spacing < div) && (phi2_low_at < div) &&
           (max_stretch < (1 << sw));
  endfunction

endpackage

// File: rtl/clken_sequencer_if.sv
// clken_sequencer_if: control inputs and enable outputs of the sequencer.
//   stretch, step_mode, step_req       - driven by the system (master)
//   cpu_clken, cpu_clken1, sub_en,
//   phi2, stretching, cycle_count      - driven by the sequencer (slave)
interface clken_sequencer_if #(
  parameter int SW   = 2,
  parameter int NSUB = 4
);
  logic [SW-1:0]   stretch;
  logic            step_mode;
  logic            step_req;
  logic            cpu_clken;
  logic            cpu_clken1;
  logic [NSUB-1:0] sub_en;
  logic            phi2;
  logic            stretching;
  logic [31:0]     cycle_count;

  modport master (
    output stretch, step_mode, step_req,
    input  cpu_clken, cpu_clken1, sub_en, phi2, stretching, cycle_count
  );

  modport slave (
    input  stretch, step_mode, step_req,
    output cpu_clken, cpu_clken1, sub_en, phi2, stretching, cycle_count
  );
endinterface

// File: rtl/clken_step_ctl.sv
// clken_step_ctl: single-step request tracking.
//   clk, reset    - system clock, async active-high reset
//   step_req      - synchronous level; each rising edge grants one bus cycle
//   step_mode     - when low, nothing is held pending
//   issue         - a bus cycle is being issued this clock
//   step_pending  - one granted step not yet consumed
module clken_step_ctl (
  input  logic clk,
  input  logic reset,
  input  logic step_req,
  input  logic step_mode,
  input  logic issue,
  output logic step_pending
);

  logic req_q;
  logic req_rise;

  assign req_rise = step_req & ~req_q;

  // NOTE: asynchronous reset lives in the sensitivity list; every flop here
  // is cleared the moment reset rises, not at the next clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      req_q <= step_req;
      // Clear has priority: an edge arriving with the issue it would have
      // granted is consumed by it, and leaving step mode drops the request.
      // A second edge while one is pending just re-sets a set flag (no queue).
      if (issue || !step_mode) step_pending <= 1'b0;
      else if (req_rise)       step_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/clken_sequencer.sv
// clken_sequencer: bus-cycle enable generator for the 65C02 system.
//   clk, reset - system clock, async active-high reset
//   bus        - clken_sequencer_if slave: stretch/step inputs; cpu_clken,
//                cpu_clken1, sub_en, phi2, stretching, cycle_count outputs
// A free-running period counter defines DIV-clock slots; a bus cycle is issued
// at the last count of a slot unless wait states or step mode hold it back.
module clken_sequencer
  import clken_pkg::*;
#(
  parameter int DIV         = DEF_DIV,
  parameter int NSUB        = DEF_NSUB,
  parameter int SUB_SPACING = DEF_SUB_SPACING,
  parameter int PHI2_LOW_AT = 24,
  parameter int MAX_STRETCH = 3,
  parameter int SW          = 2
) (
  input logic            clk,
  input logic            reset,
  clken_sequencer_if.slave bus
);

  localparam int CW = clog2(DIV);

  if (!params_ok(DIV, NSUB, SUB_SPACING, PHI2_LOW_AT, MAX_STRETCH, SW)) begin : g_bad_params
    $error("clken_sequencer: illegal parameter set");
  end

  logic [CW-1:0]   cnt;
  logic [SW-1:0]   stretch_cnt;
  logic [SW-1:0]   stretch_clamped;
  logic            last;
  logic            issue;
  logic            step_pending;
  logic            cpu_clken_q;
  logic            cpu_clken1_q;
  logic [NSUB-1:0] sub_en_q;
  logic            phi2_q;
  logic [31:0]     cycle_count_q;

  assign last  = (cnt == CW'(DIV - 1));
  // step_mode is only looked at here, so a change takes effect at the next
  // slot boundary.
  assign issue = last && (stretch_cnt == '0) && (!bus.step_mode || step_pending);

  assign stretch_clamped = (bus.stretch > SW'(MAX_STRETCH)) ? SW'(MAX_STRETCH)
                                                            : bus.stretch;

  clken_step_ctl u_step (
    .clk          (clk),
    .reset        (reset),
    .step_req     (bus.step_req),
    .step_mode    (bus.step_mode),
    .issue        (issue),
    .step_pending (step_pending)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      stretch_cnt   <= '0;
      cpu_clken_q   <= 1'b0;
      cpu_clken1_q  <= 1'b0;
      sub_en_q      <= '0;
      phi2_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      // The counter never stalls, so sub-enables keep real time during
      // stretch and step waits.
      cnt          <= last ? '0 : cnt + 1'b1;
      cpu_clken_q  <= issue;
      cpu_clken1_q <= cpu_clken_q;

      // Wait states are sampled once per bus cycle (when the address is
      // stable, one clock after the CPU advanced) and burned off one slot
      // boundary at a time.
      if (cpu_clken1_q)                   stretch_cnt <= stretch_clamped;
      else if (last && stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;

      for (int i = 0; i < NSUB; i++) begin
        sub_en_q[i] <= (cnt == CW'((i + 1) * SUB_SPACING));
      end

      if (issue)                           phi2_q <= 1'b1;
      else if (cnt == CW'(PHI2_LOW_AT))    phi2_q <= 1'b0;

      if (issue) cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign bus.cpu_clken   = cpu_clken_q;
  assign bus.cpu_clken1  = cpu_clken1_q;
  assign bus.sub_en      = sub_en_q;
  assign bus.phi2        = phi2_q;
  assign bus.stretching  = (stretch_cnt != '0);
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_clken_sequencer.sv
// tb_clken_sequencer: directed bench for clken_sequencer.
// dut_a uses the defaults; dut_b clamps wait states at 1. Both share clk/reset.
// Outputs are sampled on the falling edge; "edge n" is the n-th rising edge
// after reset release.
module tb_clken_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clken_sequencer_if #(.SW(2), .NSUB(4)) ia ();
  clken_sequencer_if #(.SW(2), .NSUB(4)) ib ();

  clken_sequencer dut_a (.clk(clk), .reset(reset), .bus(ia));
  clken_sequencer #(.MAX_STRETCH(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steps until the selected DUT shows cpu_clken (bounded). Also counts
  // clocks with stretching high and sub_en[0] pulses seen along the way.
  task automatic wait_clken(input bit sel_b, input int budget,
                            output int steps, output int st_hi, output int s0);
    steps = 0; st_hi = 0; s0 = 0;
    while (1) begin
      @(negedge clk);
      steps++;
      if (sel_b ? ib.stretching : ia.stretching) st_hi++;
      if (sel_b ? ib.sub_en[0]  : ia.sub_en[0])  s0++;
      if (sel_b ? ib.cpu_clken  : ia.cpu_clken)  break;
      if (steps >= budget) break;
    end
  endtask

  task automatic count_clken(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (ia.cpu_clken) pulses++;
    end
  endtask

  function automatic logic [7:0] pack_a();
    return {ia.cpu_clken, ia.cpu_clken1, ia.sub_en, ia.phi2, ia.stretching};
  endfunction

  typedef struct {
    int          n;        // sample after edge n
    logic        clken;
    logic        clken1;
    logic [3:0]  sub;
    logic        phi2;
    logic [31:0] cc;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int steps, st_hi, s0, pulses, cur;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = '{1,   1'b0, 1'b0, 4'b0000, 1'b0, 32'd0};
    vecs[1]  = '{9,   1'b0, 1'b0, 4'b0001, 1'b0, 32'd0};
    vecs[2]  = '{49,  1'b0, 1'b0, 4'b0000, 1'b0, 32'd0};
    vecs[3]  = '{50,  1'b1, 1'b0, 4'b0000, 1'b1, 32'd1};
    vecs[4]  = '{51,  1'b0, 1'b1, 4'b0000, 1'b1, 32'd1};
    vecs[5]  = '{52,  1'b0, 1'b0, 4'b0000, 1'b1, 32'd1};
    vecs[6]  = '{59,  1'b0, 1'b0, 4'b0001, 1'b1, 32'd1};
    vecs[7]  = '{67,  1'b0, 1'b0, 4'b0010, 1'b1, 32'd1};
    vecs[8]  = '{74,  1'b0, 1'b0, 4'b0000, 1'b1, 32'd1};
    vecs[9]  = '{75,  1'b0, 1'b0, 4'b0100, 1'b0, 32'd1};
    vecs[10] = '{83,  1'b0, 1'b0, 4'b1000, 1'b0, 32'd1};
    vecs[11] = '{84,  1'b0, 1'b0, 4'b0000, 1'b0, 32'd1};
    vecs[12] = '{99,  1'b0, 1'b0, 4'b0000, 1'b0, 32'd1};
    vecs[13] = '{100, 1'b1, 1'b0, 4'b0000, 1'b1, 32'd2};
    vecs[14] = '{499, 1'b0, 1'b0, 4'b0000, 1'b0, 32'd9};
    vecs[15] = '{500, 1'b1, 1'b0, 4'b0000, 1'b1, 32'd10};

    reset = 1'b1;
    ia.stretch = '0; ia.step_mode = 1'b0; ia.step_req = 1'b0;
    ib.stretch = '0; ib.step_mode = 1'b0; ib.step_req = 1'b0;
    step_clk(3);
    check("reset_outputs", {56'd0, pack_a()}, 64'd0);
    check("reset_cycle_count", {32'd0, ia.cycle_count}, 64'd0);
    reset = 1'b0;

    // Free-running slots, no stretch, no step.
    cur = 0;
    for (int v = 0; v < NV; v++) begin
      step_clk(vecs[v].n - cur);
      cur = vecs[v].n;
      check($sformatf("vec_n%0d_outputs", vecs[v].n), {56'd0, pack_a()},
            {56'd0, vecs[v].clken, vecs[v].clken1, vecs[v].sub, vecs[v].phi2, 1'b0});
      check($sformatf("vec_n%0d_cycle_count", vecs[v].n), {32'd0, ia.cycle_count},
            {32'd0, vecs[v].cc});
    end

    // stretch = 2 sampled at edge 502: next issue at edge 650.
    ia.stretch = 2'd2;
    step_clk(2);
    ia.stretch = 2'd0;
    check("stretch2_stretching_start", {63'd0, ia.stretching}, 64'd1);
    wait_clken(1'b0, 300, steps, st_hi, s0);
    check("stretch2_spacing", steps, 148);
    check("stretch2_stretching_clocks", st_hi, 97);
    check("stretch2_sub_en0_pulses", s0, 3);
    check("stretch2_cycle_count", {32'd0, ia.cycle_count}, 64'd11);

    // stretch high only outside its sample clock is ignored.
    ia.stretch = 2'd3;
    step_clk(1);
    ia.stretch = 2'd0;
    wait_clken(1'b0, 200, steps, st_hi, s0);
    check("stretch_ignored_spacing", steps, 49);
    check("stretch_ignored_stretching", st_hi, 0);

    // dut_b: stretch 3 clamped to 1 -> issue at edge 800.
    ib.stretch = 2'd3;
    step_clk(2);
    ib.stretch = 2'd0;
    wait_clken(1'b1, 300, steps, st_hi, s0);
    check("clamp_spacing", steps, 98);
    check("clamp_cycle_count", {32'd0, ib.cycle_count}, 64'd15);

    // Step mode: nothing issued without a request.
    ia.step_mode = 1'b1;
    count_clken(300, pulses);
    check("step_idle_pulses", pulses, 0);
    check("step_idle_cycle_count", {32'd0, ia.cycle_count}, 64'd14);

    ia.step_req = 1'b1; step_clk(1); ia.step_req = 1'b0;
    wait_clken(1'b0, 200, steps, st_hi, s0);
    check("step1_latency", steps, 49);
    step_clk(150);
    ia.step_req = 1'b1; step_clk(1); ia.step_req = 1'b0;
    wait_clken(1'b0, 200, steps, st_hi, s0);
    check("step2_latency", steps, 49);
    check("step2_cycle_count", {32'd0, ia.cycle_count}, 64'd16);
    count_clken(100, pulses);
    check("step2_no_extra", pulses, 0);

    // Two edges within one slot grant a single cycle.
    ia.step_req = 1'b1; step_clk(1); ia.step_req = 1'b0;
    step_clk(3);
    ia.step_req = 1'b1; step_clk(1); ia.step_req = 1'b0;
    wait_clken(1'b0, 200, steps, st_hi, s0);
    check("double_edge_latency", steps, 45);
    check("double_edge_pending", {63'd0, dut_a.u_step.step_pending}, 64'd0);
    count_clken(100, pulses);
    check("double_edge_no_extra", pulses, 0);

    // Edge landing on the issuing clock is consumed by that issue.
    ia.step_req = 1'b1; step_clk(1); ia.step_req = 1'b0;
    step_clk(48);
    ia.step_req = 1'b1; step_clk(1);
    check("edge_at_issue_clken", {63'd0, ia.cpu_clken}, 64'd1);
    ia.step_req = 1'b0;
    check("edge_at_issue_pending", {63'd0, dut_a.u_step.step_pending}, 64'd0);
    count_clken(100, pulses);
    check("edge_at_issue_no_extra", pulses, 0);
    check("step_total_cycle_count", {32'd0, ia.cycle_count}, 64'd18);

    // Reset in the middle of a stretched cycle.
    ia.step_mode = 1'b0;
    wait_clken(1'b0, 200, steps, st_hi, s0);
    check("resume_free_run", steps, 50);
    ia.stretch = 2'd2;
    step_clk(2);
    ia.stretch = 2'd0;
    step_clk(10);
    check("mid_stretch_cnt", {62'd0, dut_a.stretch_cnt}, 64'd2);
    check("mid_stretch_phi2", {63'd0, ia.phi2}, 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {56'd0, pack_a()}, 64'd0);
    check("async_reset_cycle_count", {32'd0, ia.cycle_count}, 64'd0);
    check("async_reset_stretch_cnt", {62'd0, dut_a.stretch_cnt}, 64'd0);
    step_clk(2);
    reset = 1'b0;
    wait_clken(1'b0, 200, steps, st_hi, s0);
    check("post_reset_first_clken", steps, 50);
    check("post_reset_cycle_count", {32'd0, ia.cycle_count}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
